// File: rtl/voter_pkg.sv
// Shared types and helpers for the voter_tally session voter.
package voter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_e;

    localparam logic [2:0] RES_PASS = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_FAIL = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Wide enough for tallies of up to 32 voters.
    localparam int unsigned VOTE_W = 6;

    function automatic logic [2:0] verdict(input logic [VOTE_W-1:0] yes,
                                           input logic [VOTE_W-1:0] no);
        if (yes > no) return RES_PASS;
        if (no > yes) return RES_FAIL;
        return RES_TIE;
    endfunction

endpackage

// File: rtl/voter_popcount.sv
// Counts this cycle's newly accepted yes and no ballots.
module voter_popcount #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     i_accept,
    input  logic [N-1:0]     i_val,
    output logic [CNT_W-1:0] o_new_yes,
    output logic [CNT_W-1:0] o_new_no
);

    always_comb begin
        o_new_yes = '0;
        o_new_no  = '0;
        for (int i = 0; i < N; i++) begin
            if (i_accept[i]) begin
                if (i_val[i]) o_new_yes = o_new_yes + CNT_W'(1);
                else          o_new_no  = o_new_no + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/voter_tally.sv
// Session-based N-voter tally with registered PASS/TIE/FAIL verdict.
// Define VOTER_QUORUM_EN to suppress the verdict when fewer than QUORUM ballots are cast.
module voter_tally
    import voter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned QUORUM  = 3,
    localparam int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_close,
    input  logic [N-1:0]     i_vote_valid,
    input  logic [N-1:0]     i_vote_val,
    output logic             o_busy,
    output logic [N-1:0]     o_voted,
    output logic [CNT_W-1:0] o_yes_cnt,
    output logic [CNT_W-1:0] o_no_cnt,
    output logic [2:0]       o_result,
    output logic             o_result_valid,
    output logic             o_dup_err
);

    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef VOTER_QUORUM_EN
    localparam bit QUORUM_EN = 1'b1;
`else
    localparam bit QUORUM_EN = 1'b0;
`endif

    state_e             r_state, w_state_nxt;
    logic               r_busy;
    logic [N-1:0]       r_voted;
    logic [CNT_W-1:0]   r_yes, r_no;
    logic [2:0]         r_result;
    logic               r_result_valid;
    logic               r_dup;
    logic [TMR_W-1:0]   r_timer;

    logic [N-1:0]       w_accept, w_voted_nxt;
    logic               w_dup, w_timeout, w_exit, w_quorum_ok;
    logic [CNT_W-1:0]   w_new_yes, w_new_no, w_yes_nxt, w_no_nxt;
    logic [2:0]         w_verdict;

    assign w_accept    = i_vote_valid & ~r_voted;
    assign w_dup       = |(i_vote_valid & r_voted);
    assign w_voted_nxt = r_voted | w_accept;

    voter_popcount #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_popcount (
        .i_accept  (w_accept),
        .i_val     (i_vote_val),
        .o_new_yes (w_new_yes),
        .o_new_no  (w_new_no)
    );

    assign w_yes_nxt = r_yes + w_new_yes;
    assign w_no_nxt  = r_no + w_new_no;

    assign w_timeout = (TIMEOUT != 0) && (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_exit    = i_close | (&w_voted_nxt) | w_timeout;

    // Verdict uses the tallies including ballots landing in the exit cycle.
    assign w_quorum_ok = !QUORUM_EN || ((32'(w_yes_nxt) + 32'(w_no_nxt)) >= QUORUM);
    assign w_verdict   = w_quorum_ok ? verdict(VOTE_W'(w_yes_nxt), VOTE_W'(w_no_nxt))
                                     : RES_NONE;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = COLLECT;
            COLLECT: if (w_exit)  w_state_nxt = RESULT;
            RESULT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_voted        <= '0;
            r_yes          <= '0;
            r_no           <= '0;
            r_result       <= RES_NONE;
            r_result_valid <= 1'b0;
            r_dup          <= 1'b0;
            r_timer        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_busy         <= (w_state_nxt == COLLECT);
            r_result_valid <= (w_state_nxt == RESULT);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_voted <= '0;
                        r_yes   <= '0;
                        r_no    <= '0;
                        r_dup   <= 1'b0;
                        r_timer <= '0;
                    end
                end
                COLLECT: begin
                    r_voted <= w_voted_nxt;
                    r_yes   <= w_yes_nxt;
                    r_no    <= w_no_nxt;
                    r_dup   <= r_dup | w_dup;
                    if (r_timer != {TMR_W{1'b1}}) r_timer <= r_timer + TMR_W'(1);
                    if (w_exit) r_result <= w_verdict;
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_voted        = r_voted;
    assign o_yes_cnt      = r_yes;
    assign o_no_cnt       = r_no;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_dup_err      = r_dup;

endmodule

// File: tb/tb_voter_tally.sv
// Self-checking bench for voter_tally: directed scenarios plus randomized sessions vs a model.
module tb_voter_tally;

    localparam int unsigned N       = 4;
    localparam int unsigned TIMEOUT = 5;
    localparam int unsigned QUORUM  = 3;
    localparam int unsigned CNT_W   = $clog2(N + 1);

`ifdef VOTER_QUORUM_EN
    localparam logic [2:0] EXP_T2 = 3'b000;
    localparam logic [2:0] EXP_T3 = 3'b000;
    localparam logic [2:0] EXP_T4 = 3'b000;
`else
    localparam logic [2:0] EXP_T2 = 3'b010;
    localparam logic [2:0] EXP_T3 = 3'b100;
    localparam logic [2:0] EXP_T4 = 3'b010;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             i_start = 1'b0;
    logic             i_close = 1'b0;
    logic [N-1:0]     i_vote_valid = '0;
    logic [N-1:0]     i_vote_val = '0;
    logic             o_busy;
    logic [N-1:0]     o_voted;
    logic [CNT_W-1:0] o_yes_cnt, o_no_cnt;
    logic [2:0]       o_result;
    logic             o_result_valid;
    logic             o_dup_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    voter_tally #(
        .N       (N),
        .TIMEOUT (TIMEOUT),
        .QUORUM  (QUORUM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_close        (i_close),
        .i_vote_valid   (i_vote_valid),
        .i_vote_val     (i_vote_val),
        .o_busy         (o_busy),
        .o_voted        (o_voted),
        .o_yes_cnt      (o_yes_cnt),
        .o_no_cnt       (o_no_cnt),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_dup_err      (o_dup_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic [N-1:0] voted,
                           input int yes, input int no, input logic [2:0] res,
                           input logic rv, input logic dup);
        chk({tag, ".busy"},   32'(o_busy), 32'(busy));
        chk({tag, ".voted"},  32'(o_voted), 32'(voted));
        chk({tag, ".yes"},    32'(o_yes_cnt), yes);
        chk({tag, ".no"},     32'(o_no_cnt), no);
        chk({tag, ".result"}, 32'(o_result), 32'(res));
        chk({tag, ".rvalid"}, 32'(o_result_valid), 32'(rv));
        chk({tag, ".dup"},    32'(o_dup_err), 32'(dup));
    endtask

    // Behavioural model: session phase, per-voter ballot record, plain integer tallies.
    int         m_phase;   // 0 idle, 1 collecting, 2 verdict cycle
    logic [N-1:0] m_voted;
    int         m_yes, m_no, m_age;
    bit         m_dup, m_rv;
    logic [2:0] m_res;

    function automatic logic [2:0] ref_verdict(input int y, input int n);
`ifdef VOTER_QUORUM_EN
        if (y + n < QUORUM) return 3'b000;
`endif
        if (y > n) return 3'b100;
        if (n > y) return 3'b001;
        return 3'b010;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_voted = '0; m_yes = 0; m_no = 0; m_age = 0;
            m_dup = 0; m_rv = 0; m_res = 3'b000;
        end else begin
            case (m_phase)
                0: begin
                    if (i_start) begin
                        m_phase = 1; m_voted = '0; m_yes = 0; m_no = 0;
                        m_dup = 0; m_age = 0;
                    end
                end
                1: begin
                    for (int i = 0; i < N; i++) begin
                        if (i_vote_valid[i]) begin
                            if (m_voted[i]) m_dup = 1;
                            else begin
                                m_voted[i] = 1'b1;
                                if (i_vote_val[i]) m_yes++;
                                else m_no++;
                            end
                        end
                    end
                    if (i_close || (m_yes + m_no == N) ||
                        (TIMEOUT != 0 && m_age + 1 == TIMEOUT)) begin
                        m_phase = 2;
                        m_rv = 1;
                        m_res = ref_verdict(m_yes, m_no);
                    end
                    m_age++;
                end
                default: begin
                    m_phase = 0;
                    m_rv = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.busy",   32'(o_busy), 32'(m_phase == 1));
            chk("m.voted",  32'(o_voted), 32'(m_voted));
            chk("m.yes",    32'(o_yes_cnt), m_yes);
            chk("m.no",     32'(o_no_cnt), m_no);
            chk("m.result", 32'(o_result), 32'(m_res));
            chk("m.rvalid", 32'(o_result_valid), 32'(m_rv));
            chk("m.dup",    32'(o_dup_err), 32'(m_dup));
        end
    end

    task automatic drive(input logic s, input logic c, input logic [N-1:0] vv,
                         input logic [N-1:0] vl);
        i_start = s; i_close = c; i_vote_valid = vv; i_vote_val = vl;
        @(posedge clk);
        #1;
        i_start = 0; i_close = 0; i_vote_valid = '0; i_vote_val = '0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset", 0, 4'b0000, 0, 0, 3'b000, 0, 0);

        // Full turnout auto-close
        drive(1, 0, 4'b0000, 4'b0000);
        chk_all("t1.open", 1, 4'b0000, 0, 0, 3'b000, 0, 0);
        drive(0, 0, 4'b1111, 4'b0111);
        chk_all("t1", 0, 4'b1111, 3, 1, 3'b100, 1, 0);
        drive(0, 0, 4'b0000, 4'b0000);
        chk("t1.after.rvalid", 32'(o_result_valid), 0);

        // Partial turnout, explicit close
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 0, 4'b0011, 4'b0001);
        drive(0, 1, 4'b0000, 4'b0000);
        chk_all("t2", 0, 4'b0011, 1, 1, EXP_T2, 1, 0);
        drive(0, 0, 4'b0000, 4'b0000);

        // Repeat ballot ignored but flagged
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 0, 4'b0001, 4'b0001);
        drive(0, 0, 4'b0001, 4'b0000);
        chk_all("t3.dup", 1, 4'b0001, 1, 0, EXP_T2, 0, 1);
        drive(0, 1, 4'b0000, 4'b0000);
        chk_all("t3", 0, 4'b0001, 1, 0, EXP_T3, 1, 1);
        drive(0, 0, 4'b0000, 4'b0000);

        // Timeout with no ballots
        drive(1, 0, 4'b0000, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 4'b0000, 4'b0000);
            if (k < 5) chk("t4.wait.rvalid", 32'(o_result_valid), 0);
            else       chk_all("t4", 0, 4'b0000, 0, 0, EXP_T4, 1, 0);
        end
        drive(0, 0, 4'b0000, 4'b0000);

        // Asynchronous reset mid-session
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 0, 4'b0011, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk_all("t5.rst", 0, 4'b0000, 0, 0, 3'b000, 0, 0);
        rst_n = 1'b1;
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 0, 4'b1111, 4'b1000);
        chk_all("t5.new", 0, 4'b1111, 1, 3, 3'b001, 1, 0);

        // Commands outside their states are ignored
        drive(0, 0, 4'b0000, 4'b0000);
        drive(0, 1, 4'b1111, 4'b1111);
        chk_all("t6.idle", 0, 4'b1111, 1, 3, 3'b001, 0, 0);
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 1, 4'b0000, 4'b0000);
        chk_all("t6.close", 0, 4'b0000, 0, 0, EXP_T4, 1, 0);
        drive(1, 1, 4'b1111, 4'b1111);
        chk_all("t6.res", 0, 4'b0000, 0, 0, EXP_T4, 0, 0);
        drive(0, 0, 4'b0000, 4'b0000);
        chk("t6.still_idle", 32'(o_busy), 0);

        // Randomized sessions
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            drive(($urandom % 4) == 0, ($urandom % 8) == 0,
                  N'($urandom & $urandom), N'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
